entity_line_scanner: RTL and testbench

Per-scanline scheduler for the entity table. When the renderer pulses `line_start`, the block walks the entity table from address 0 to `entities_number-1`, reading each 21-bit entry {type, row, col}. It streams every entity whose vertical extent covers the current line to the line renderer over a valid/ready handshake. It sits between the entity table (registered, one-cycle read latency) and the per-line sprite compositor.

---
 rtl/entity_line_scanner.sv | 159 +++++++++++++++
 tb/tb_entity_line_scanner.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/entity_line_scanner.sv
// entity_line_scanner: per-scanline scheduler for the entity table.
// On line_start it walks table entries 0..N-1 (one-cycle registered read),
// keeps those whose vertical extent covers the latched line, and streams
// them to the sprite compositor over a valid/ready handshake.
module entity_line_scanner #(
  parameter int ENT_H    = 48,
  parameter int MAX_HITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [7:0]  entities_number,
  output logic [7:0]  address_read_ent,
  input  logic [20:0] data_read_ent,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic [2:0]  hit_type,
  output logic [8:0]  hit_col,
  output logic [5:0]  hit_dy,
  output logic [7:0]  hit_count,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, EVAL, DRAIN} state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  idx;
  logic [7:0]  num_lat;
  logic [8:0]  y_lat;

  logic [2:0]  ent_type;
  logic [8:0]  ent_row;
  logic [8:0]  ent_col;
  logic [9:0]  row_end;
  logic        is_hit;
  logic        slot_free;
  logic        count_full;
  logic        last_entry;

  logic        start_scan;
  logic        load_hit;
  logic        drop_hit;
  logic        advance;
  logic        finish;

  assign ent_type   = data_read_ent[20:18];
  assign ent_row    = data_read_ent[17:9];
  assign ent_col    = data_read_ent[8:0];
  // Row end is formed at 10 bits so rows near the bottom cannot wrap.
  assign row_end    = {1'b0, ent_row} + 10'(ENT_H);
  assign is_hit     = (ent_type != 3'd7) && (ent_row <= y_lat) &&
                      ({1'b0, y_lat} < row_end);
  assign slot_free  = !hit_valid || hit_ready;
  assign count_full = (hit_count >= 8'(MAX_HITS));
  assign last_entry = ((idx + 8'd1) == num_lat);
  assign busy       = (state != IDLE) || done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    next_state = state;
    start_scan = 1'b0;
    load_hit   = 1'b0;
    drop_hit   = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          start_scan = 1'b1;
          next_state = (entities_number == 8'd0) ? DRAIN : READ;
        end
      end
      READ: begin
        next_state = EVAL;
      end
      EVAL: begin
        if (is_hit && count_full) begin
          drop_hit = 1'b1;
          advance  = 1'b1;
        end else if (is_hit && slot_free) begin
          load_hit = 1'b1;
          advance  = 1'b1;
        end else if (!is_hit) begin
          advance  = 1'b1;
        end
        if (advance) begin
          next_state = last_entry ? DRAIN : READ;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Scan context, table address, hit output register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx              <= 8'd0;
      num_lat          <= 8'd0;
      y_lat            <= 9'd0;
      address_read_ent <= 8'd0;
      hit_valid        <= 1'b0;
      hit_type         <= 3'd0;
      hit_col          <= 9'd0;
      hit_dy           <= 6'd0;
      hit_count        <= 8'd0;
      overflow         <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= finish;
      if (start_scan) begin
        y_lat            <= line_y;
        num_lat          <= entities_number;
        idx              <= 8'd0;
        address_read_ent <= 8'd0;
        hit_count        <= 8'd0;
        overflow         <= 1'b0;
      end
      if (advance) begin
        idx <= idx + 8'd1;
        if (!last_entry) begin
          address_read_ent <= idx + 8'd1;
        end
      end
      if (load_hit) begin
        hit_valid <= 1'b1;
        hit_type  <= ent_type;
        hit_col   <= ent_col;
        hit_dy    <= 6'(y_lat - ent_row);
        hit_count <= hit_count + 8'd1;
      end else if (hit_ready) begin
        hit_valid <= 1'b0;
      end
      if (drop_hit) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_entity_line_scanner.sv
// Testbench for entity_line_scanner: a table model feeds two instances
// (default MAX_HITS and MAX_HITS=4); expected hits are queued at scan start
// and popped as the DUT hands them over.
module tb_entity_line_scanner;

  localparam int ENT_H = 48;

  logic        clk;
  logic        rst;
  logic        line_start0, line_start1;
  logic [8:0]  line_y;
  logic [7:0]  ent_n;
  logic [7:0]  addr0, addr1;
  logic [20:0] data0, data1;
  logic        hv0, hv1, hr0, hr1;
  logic [2:0]  ht0, ht1;
  logic [8:0]  hc0, hc1;
  logic [5:0]  hd0, hd1;
  logic [7:0]  cnt0, cnt1;
  logic        ov0, ov1, busy0, busy1, done0, done1;

  logic [20:0] mem [256];
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  int checks = 0;
  int failures = 0;
  int sel = 0;
  bit bp = 0;
  int exp_count = 0;
  bit exp_ovf = 0;

  logic        o_done, o_busy, o_ovf, o_hv;
  logic [7:0]  o_cnt;

  assign o_done = (sel != 0) ? done1 : done0;
  assign o_busy = (sel != 0) ? busy1 : busy0;
  assign o_ovf  = (sel != 0) ? ov1   : ov0;
  assign o_hv   = (sel != 0) ? hv1   : hv0;
  assign o_cnt  = (sel != 0) ? cnt1  : cnt0;

  entity_line_scanner #(.ENT_H(ENT_H), .MAX_HITS(16)) u_main (
    .clk(clk), .rst(rst), .line_start(line_start0), .line_y(line_y),
    .entities_number(ent_n), .address_read_ent(addr0), .data_read_ent(data0),
    .hit_valid(hv0), .hit_ready(hr0), .hit_type(ht0), .hit_col(hc0),
    .hit_dy(hd0), .hit_count(cnt0), .overflow(ov0), .busy(busy0), .done(done0)
  );

  entity_line_scanner #(.ENT_H(ENT_H), .MAX_HITS(4)) u_ovf (
    .clk(clk), .rst(rst), .line_start(line_start1), .line_y(line_y),
    .entities_number(ent_n), .address_read_ent(addr1), .data_read_ent(data1),
    .hit_valid(hv1), .hit_ready(hr1), .hit_type(ht1), .hit_col(hc1),
    .hit_dy(hd1), .hit_count(cnt1), .overflow(ov1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered table read, one-cycle latency like the real entity table.
  always @(posedge clk) begin
    data0 <= mem[addr0];
    data1 <= mem[addr1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build expected hit list from the table model, then pulse line_start.
  task automatic applyStimulus(input int s, input logic [8:0] y, input logic [7:0] n, input int max_hits);
    int cnt;
    logic [20:0] e;
    logic [8:0] row;
    cnt = 0;
    exp_ovf = 0;
    for (int i = 0; i < int'(n); i++) begin
      e = mem[i];
      row = e[17:9];
      if (e[20:18] != 3'd7 && row <= y && int'(y) < int'(row) + ENT_H) begin
        if (cnt < max_hits) begin
          if (s != 0) q1.push_back({e[20:18], e[8:0], 6'(y - row)});
          else        q0.push_back({e[20:18], e[8:0], 6'(y - row)});
          cnt++;
        end else begin
          exp_ovf = 1;
        end
      end
    end
    exp_count = cnt;
    sel = s;
    @(negedge clk);
    line_y = y;
    ent_n = n;
    if (s != 0) line_start1 = 1'b1;
    else        line_start0 = 1'b1;
  endtask

  // Wait for done with a cycle budget, then check the end-of-scan state.
  task automatic waitDone(input string tag, input int exp_cyc, input int glitch_at);
    int k;
    bit seen;
    int qs;
    k = 0;
    seen = 0;
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        line_start0 = 1'b0;
        line_start1 = 1'b0;
        checkOutput({tag, "_busy_c1"}, 32'(o_busy), 32'd1);
        checkOutput({tag, "_ovf_c1"}, 32'(o_ovf), 32'd0);
      end
      if (glitch_at > 0 && k == glitch_at) begin
        line_y = 9'd0;
        ent_n = 8'd5;
        line_start0 = 1'b1;
      end
      if (glitch_at > 0 && k == glitch_at + 1) line_start0 = 1'b0;
      if (o_done) seen = 1;
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (exp_cyc > 0) checkOutput({tag, "_done_cycle"}, 32'(k), 32'(exp_cyc));
    qs = (sel != 0) ? q1.size() : q0.size();
    checkOutput({tag, "_pending"}, 32'(qs), 32'd0);
    checkOutput({tag, "_hv_at_done"}, 32'(o_hv), 32'd0);
    checkOutput({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
    checkOutput({tag, "_hit_count"}, 32'(o_cnt), 32'(exp_count));
    checkOutput({tag, "_overflow"}, 32'(o_ovf), 32'(exp_ovf));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  // Scoreboard and stall-stability monitor for the main instance.
  logic        stall_prev0 = 1'b0;
  logic [17:0] held0;
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      stall_prev0 = 1'b0;
    end else begin
      if (stall_prev0) checkOutput("stall_stable", {13'd0, hv0, ht0, hc0, hd0}, {13'd0, 1'b1, held0});
      if (hv0 && hr0) begin
        checkOutput("hit_expected", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          checkOutput("hit_value", {14'd0, ht0, hc0, hd0}, {14'd0, e});
        end
      end
      stall_prev0 = hv0 && !hr0;
      held0 = {ht0, hc0, hd0};
    end
  end

  // Scoreboard for the small-MAX_HITS instance.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst && hv1 && hr1) begin
      checkOutput("ovf_hit_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("ovf_hit_value", {14'd0, ht1, hc1, hd1}, {14'd0, e});
      end
    end
  end

  // Consumer ready: always ready, or random when backpressure is enabled.
  initial begin
    hr0 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      hr0 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    rst = 1'b1;
    line_start0 = 1'b0;
    line_start1 = 1'b0;
    line_y = 9'd0;
    ent_n = 8'd0;
    hr1 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i < 100) mem[i] = {3'd4, 9'((i / 10) * 48), 9'((i % 10) * 48)};
      else         mem[i] = {3'd7, 9'd0, 9'd0};
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_addr", 32'(addr0), 32'd0);
    checkOutput("rst_hv", 32'(hv0), 32'd0);
    checkOutput("rst_fields", {14'd0, ht0, hc0, hd0}, 32'd0);
    checkOutput("rst_count", 32'(cnt0), 32'd0);
    checkOutput("rst_flags", {29'd0, ov0, busy0, done0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] grid line_y=50");
    applyStimulus(0, 9'd50, 8'd100, 16);
    waitDone("grid50", 202, 0);

    $display("[TB] boundaries");
    applyStimulus(0, 9'd479, 8'd100, 16);
    waitDone("y479", 202, 0);
    applyStimulus(0, 9'd480, 8'd100, 16);
    waitDone("y480", 202, 0);
    applyStimulus(0, 9'd47, 8'd100, 16);
    waitDone("y47", 202, 0);

    $display("[TB] backpressure");
    bp = 1;
    applyStimulus(0, 9'd50, 8'd100, 16);
    waitDone("bp", 0, 0);
    bp = 0;
    @(negedge clk);

    $display("[TB] overflow");
    applyStimulus(1, 9'd50, 8'd100, 4);
    waitDone("ovf", 202, 0);
    applyStimulus(1, 9'd480, 8'd100, 4);
    waitDone("ovf_next", 202, 0);

    $display("[TB] edge cases");
    applyStimulus(0, 9'd50, 8'd0, 16);
    waitDone("n0", 2, 0);
    mem[15] = {3'd7, 9'd48, 9'd144};
    applyStimulus(0, 9'd50, 8'd100, 16);
    waitDone("type7", 202, 0);
    mem[15] = {3'd4, 9'd48, 9'd240};
    applyStimulus(0, 9'd50, 8'd100, 16);
    waitDone("busy_ignore", 202, 20);

    $display("[TB] reset mid-scan");
    applyStimulus(0, 9'd50, 8'd100, 16);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) line_start0 = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_addr", 32'(addr0), 32'd0);
    checkOutput("mid_rst_hv", 32'(hv0), 32'd0);
    checkOutput("mid_rst_fields", {14'd0, ht0, hc0, hd0}, 32'd0);
    checkOutput("mid_rst_count", 32'(cnt0), 32'd0);
    checkOutput("mid_rst_flags", {29'd0, ov0, busy0, done0}, 32'd0);
    q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 9'd50, 8'd100, 16);
    waitDone("rst_rescan", 202, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
